// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and constants for the MEM-stage memory sequencer
package mem_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
    localparam int DEFAULT_TIMEOUT = 16;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: saturating BUSY-cycle counter flagging the last allowed wait cycle
module mem_timeout_ctr
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    // count enabled cycles, holding at TIMEOUT instead of wrapping
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en && cnt != W'(TIMEOUT)) cnt <= cnt + 1'b1;
    end
    assign expire = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: issues one req/ack transaction per load/store in MEM and stalls the pipeline until it completes
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [31:0] MEM_ALUout,
    input  logic [31:0] MEM_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] MEM_MEMout,
    output logic        stall,
    output logic        wb_bubble,
    output logic        err
);
    state_t state, next;
    logic op, misaligned, busy, expire;
    assign op = MEM_MemRead | MEM_MemWrite;
    assign misaligned = |(MEM_ALUout[1:0] & WORD_ALIGN_MASK);
    assign busy = state == BUSY;
    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk(clk),
        .reset(reset),
        .clr(!busy || mem_ack),
        .en(busy),
        .expire(expire)
    );
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end
    // next state and stall/error decode; ack beats a coinciding timeout
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = op ? (misaligned ? ERR : BUSY) : IDLE;
            BUSY:    next = mem_ack ? DONE : (expire ? ERR : BUSY);
            DONE:    next = IDLE;
            default: next = ERR;
        endcase
        stall = (state == IDLE && op) || busy || state == ERR;
        wb_bubble = stall;
        err = state == ERR;
    end
    // registered request, latched operands, and load data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            MEM_MEMout <= '0;
        end else begin
            mem_req <= next == BUSY;
            if (state == IDLE && next == BUSY) begin
                mem_we    <= MEM_MemWrite;
                mem_addr  <= MEM_ALUout;
                mem_wdata <= MEM_wdata;
            end
            if (busy && mem_ack && !mem_we) MEM_MEMout <= mem_rdata;
        end
    end
endmodule
